// File: rtl/rv_alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the divide-op encoding.
package rv_alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned FLAG_W     = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1001;

  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

endpackage

// File: rtl/rv_alu.sv
// Shared combinational ALU with {o,c,n,z} flags; c on SUB means no borrow.
module rv_alu
  import rv_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  input  logic [ALU_CTRL_W-1:0] alu_control,
  output logic [XLEN-1:0]       result_c,
  output logic [FLAG_W-1:0]     flags_c
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [XLEN:0]     sum;
  logic [SH_W-1:0]   shamt;
  logic              carry;
  logic              ovf;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    sum      = '0;
    result_c = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result_c = sum[XLEN-1:0];
        carry    = sum[XLEN];
        ovf      = (a[XLEN-1] == b[XLEN-1]) && (result_c[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
        result_c = sum[XLEN-1:0];
        carry    = sum[XLEN];
        ovf      = (a[XLEN-1] != b[XLEN-1]) && (result_c[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_XOR:  result_c = a ^ b;
      ALU_SLT:  result_c = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result_c = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLL:  result_c = a << shamt;
      ALU_SRL:  result_c = a >> shamt;
      ALU_SRA:  result_c = XLEN'($signed(a) >>> shamt);
      default:  result_c = '0;
    endcase
    flags_c = {ovf, carry, result_c[XLEN-1], result_c == '0};
  end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring division borrowing the shared ALU
// for one subtract per cycle, with sign fix-up through the ALU at the end.
module div_sequencer
  import rv_alu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [XLEN-1:0]       dividend,
  input  logic [XLEN-1:0]       divisor,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic                  alu_sel,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [FLAG_W-1:0]     alu_flags
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIX,
    DONE
  } state_e;

  state_e            state;
  div_op_e           op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   quo;
  logic [CNT_W-1:0]  cnt;
  logic              sh;
  logic              quo_neg;
  logic              rem_neg;

  logic              is_signed;
  logic              is_rem;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              take;
  logic [XLEN-1:0]   new_rem;
  logic [XLEN-1:0]   new_quo;
  logic              fix_neg;
  logic              unused_flags;

  // Operand conditioning and one restoring step, evaluated from the registered ALU operands.
  always_comb begin
    is_signed = (op_r == DIV_OP_DIV) || (op_r == DIV_OP_REM);
    is_rem    = (op_r == DIV_OP_REM) || (op_r == DIV_OP_REMU);
    abs_a     = (is_signed && a_r[XLEN-1]) ? (~a_r + XLEN'(1)) : a_r;
    abs_b     = (is_signed && b_r[XLEN-1]) ? (~b_r + XLEN'(1)) : b_r;
    // sh is the 33rd bit of the shifted remainder; when set the subtract always fits.
    take      = sh | alu_flags[FLAG_C];
    new_rem   = take ? alu_result : alu_a;
    new_quo   = {quo[XLEN-2:0], take};
    fix_neg   = is_rem ? rem_neg : quo_neg;
  end

  assign unused_flags = ^{alu_flags[FLAG_O], alu_flags[FLAG_N], alu_flags[FLAG_Z]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_r        <= DIV_OP_DIV;
      a_r         <= '0;
      b_r         <= '0;
      quo         <= '0;
      cnt         <= '0;
      sh          <= 1'b0;
      quo_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      alu_sel     <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
    end else begin
      done <= 1'b0;
      if (flush && (state != IDLE)) begin
        state       <= IDLE;
        busy        <= 1'b0;
        alu_sel     <= 1'b0;
        alu_a       <= '0;
        alu_b       <= '0;
        alu_control <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_r        <= div_op_e'(op);
              a_r         <= dividend;
              b_r         <= divisor;
              state       <= SETUP;
              busy        <= 1'b1;
              alu_sel     <= 1'b1;
              alu_control <= ALU_SUB;
            end
          end

          SETUP: begin
            quo_neg <= is_signed & (a_r[XLEN-1] ^ b_r[XLEN-1]);
            rem_neg <= is_signed & a_r[XLEN-1];
            quo     <= abs_a;
            cnt     <= '0;
            sh      <= 1'b0;
            if (EARLY_OUT && (b_r == '0)) begin
              result      <= is_rem ? a_r : {XLEN{1'b1}};
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              alu_sel     <= 1'b0;
              alu_a       <= '0;
              alu_b       <= '0;
              alu_control <= '0;
            end else if (EARLY_OUT && is_signed && (a_r == {1'b1, {(XLEN-1){1'b0}}})
                         && (b_r == {XLEN{1'b1}})) begin
              result      <= is_rem ? '0 : a_r;
              state       <= DONE;
              done        <= 1'b1;
              busy        <= 1'b0;
              alu_sel     <= 1'b0;
              alu_a       <= '0;
              alu_b       <= '0;
              alu_control <= '0;
            end else begin
              state       <= ITER;
              alu_a       <= {{(XLEN-1){1'b0}}, abs_a[XLEN-1]};
              alu_b       <= abs_b;
              alu_control <= ALU_SUB;
            end
          end

          // alu_a always holds the shifted remainder for the step running this cycle.
          ITER: begin
            quo <= new_quo;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) begin
              state <= FIX;
              alu_a <= '0;
              alu_b <= is_rem ? new_rem : new_quo;
            end else begin
              alu_a <= {new_rem[XLEN-2:0], new_quo[XLEN-1]};
              sh    <= new_rem[XLEN-1];
            end
          end

          FIX: begin
            result      <= fix_neg ? alu_result : alu_b;
            state       <= DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            alu_sel     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
          end

          DONE: state <= IDLE;

          default: begin
            state       <= IDLE;
            busy        <= 1'b0;
            alu_sel     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Closed-loop bench: div_sequencer driving the shared ALU, checked against an arithmetic model.
module tb_div_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;

  int checks   = 0;
  int failures = 0;

  div_sequencer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_control(alu_control),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  rv_alu u_alu (
    .a          (alu_a),
    .b          (alu_b),
    .alu_control(alu_control),
    .result_c   (alu_result),
    .flags_c    (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics straight from the arithmetic definition.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int  sa;
    int  sb;
    logic ovf;
    sa  = int'(a);
    sb  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      2'd0:    ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      2'd1:    ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
    if ((o == 2'd0 || o == 2'd2) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits up to 100 cycles for done; optionally pulses a stray start in cycle poke.
  task automatic wait_done(output logic [31:0] res, output int lat, output int bad, input int poke);
    res = '0;
    lat = -1;
    bad = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start = (poke != 0) && (n == poke);
      if (start) begin
        op       = 2'd1;
        dividend = 32'h0000_DEAD;
        divisor  = 32'd3;
      end
      if (done) begin
        if (busy || alu_sel || alu_a != 0 || alu_b != 0 || alu_control != 0) bad++;
        res = result;
        lat = n;
        break;
      end else if (!busy || !alu_sel) begin
        bad++;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bad);
    start_op(o, a, b);
    wait_done(res, lat, bad, 0);
  endtask

  task automatic count_activity(input int cycles, output int act);
    act = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (busy || done || alu_sel) act++;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] last_exp;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    int          lat;
    int          bad;
    int          act;

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         35};
    vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          35};
    vecs[2]  = '{2'd0, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  35};
    vecs[3]  = '{2'd2, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  35};
    vecs[4]  = '{2'd2, 32'd100,        32'hFFFF_FFF9,  32'd2,          35};
    vecs[5]  = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35};
    vecs[6]  = '{2'd3, 32'hFFFF_FFFF,  32'd2,          32'd1,          35};
    vecs[7]  = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vecs[8]  = '{2'd2, 32'd5,          32'd0,          32'd5,          2};
    vecs[9]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
    vecs[10] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
    vecs[11] = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vecs[12] = '{2'd0, 32'd0,          32'd3,          32'd0,          35};
    vecs[13] = '{2'd0, 32'h8000_0000,  32'd2,          32'hC000_0000,  35};

    rst_n = 1'b0; start = 1'b0; op = 2'd0; dividend = '0; divisor = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({busy, done, alu_sel, alu_control}), 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_alu_ab", alu_a | alu_b, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bad);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy_profile", i), bad, 0);
      @(negedge clk);
      check($sformatf("vec%0d_idle_alu", i),
            alu_a | alu_b | 32'({busy, done, alu_sel, alu_control}), 32'h0);
    end

    // Stray start mid-operation, then a start in the done cycle: both ignored.
    start_op(2'd1, 32'd1000, 32'd9);
    wait_done(res, lat, bad, 5);
    check("busy_start_result", res, 32'd111);
    check("busy_start_latency", lat, 35);
    check("busy_start_profile", bad, 0);
    last_exp = 32'd111;
    op = 2'd1; dividend = 32'd77; divisor = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    count_activity(40, act);
    check("done_cycle_start_ignored", act, 0);
    check("done_cycle_start_result", result, last_exp);

    // Flush in cycle 10: idle in cycle 11, no done, result kept.
    start_op(2'd0, 32'hFFFF_FC18, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'({busy, alu_sel, alu_control}), 32'h0);
    check("flush_result_kept", result, last_exp);
    count_activity(40, act);
    check("flush_no_done", act, 0);

    // flush while idle does not block an accepted start.
    flush = 1'b1;
    start_op(2'd2, 32'hFFFF_FC18, 32'd7);
    flush = 1'b0;
    wait_done(res, lat, bad, 0);
    check("idle_flush_result", res, ref_div(2'd2, 32'hFFFF_FC18, 32'd7));
    check("idle_flush_latency", lat, 35);
    last_exp = ref_div(2'd2, 32'hFFFF_FC18, 32'd7);

    // Asynchronous reset in cycle 20.
    start_op(2'd3, 32'd12345, 32'd100);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ctrl", 32'({busy, done, alu_sel, alu_control}), 32'h0);
    check("midreset_result", result, 32'h0);
    check("midreset_alu_ab", alu_a | alu_b, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_activity(40, act);
    check("midreset_no_done", act, 0);

    // Randomized back-to-back operations against the arithmetic model.
    for (int k = 0; k < 60; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = -32'($urandom_range(1, 15));
        4:       rb = 32'($urandom) >> $urandom_range(0, 31);
        default: rb = 32'($urandom);
      endcase
      run_op(ro, ra, rb, res, lat, bad);
      check($sformatf("rand%0d_result op=%0d a=%h b=%h", k, ro, ra, rb), res, ref_div(ro, ra, rb));
      check($sformatf("rand%0d_latency", k), lat, ref_lat(ro, ra, rb));
      check($sformatf("rand%0d_busy_profile", k), bad, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
